// File: rtl/spike_unpack_pkg.sv
// spike_unpack_pkg: shared types, default sizes and helpers for the spike unpack buffer.
package spike_unpack_pkg;
    localparam int P_DEF         = 64;
    localparam int GAMMA_LEN_DEF = 10;
    localparam int TICK_W        = $clog2(GAMMA_LEN_DEF + 1);
    typedef logic [TICK_W-1:0] tick_t;
    typedef enum logic [1:0] {IDLE, FILL, RUN} unpack_state_t;
    function automatic int half_len(input int gamma_len);
        return gamma_len / 2;
    endfunction
endpackage

// File: rtl/spike_unpack_bank.sv
// spike_unpack_bank: one context of ping-pong gamma storage with whole-bank clear, write and read ports.
// SPIKE_UNPACK_DUP_EN: each write also fills the following odd position.
module spike_unpack_bank import spike_unpack_pkg::*; #(
    parameter int P         = P_DEF,
    parameter int GAMMA_LEN = GAMMA_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         clr_bank_i,
    input  logic         we_i,
    input  logic         wbank_i,
    input  tick_t        waddr_i,
    input  logic [P-1:0] wdata_i,
    input  logic         rbank_i,
    input  tick_t        raddr_i,
    output logic [P-1:0] rdata_o
);
    logic [1:0][GAMMA_LEN-1:0][P-1:0] mem_q, mem_d;
    // Clear precedes the write so a tick-0 write lands on the freshly cleared bank.
    always_comb begin
        mem_d = mem_q;
        if (clr_i) mem_d[clr_bank_i] = '0;
        if (we_i) begin
            mem_d[wbank_i][waddr_i] = wdata_i;
`ifdef SPIKE_UNPACK_DUP_EN
            mem_d[wbank_i][waddr_i + tick_t'(1)] = wdata_i;
`endif
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end
    assign rdata_o = mem_q[rbank_i][raddr_i];
endmodule

// File: rtl/spike_unpack_buffer.sv
// spike_unpack_buffer: splits the time-compressed column stream into two per-context streams,
// buffering one gamma and replaying it at the original rate. Option: SPIKE_UNPACK_DUP_EN (see bank).
module spike_unpack_buffer import spike_unpack_pkg::*; #(
    parameter int P         = P_DEF,
    parameter int GAMMA_LEN = GAMMA_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         grst,
    input  logic [P-1:0] data_in,
    input  logic         in_valid,
    output logic [P-1:0] data_out0,
    output logic [P-1:0] data_out1,
    output logic         out_valid,
    output logic         overrun
);
    // tick_t width follows GAMMA_LEN_DEF; change both together.
    localparam tick_t GL_T   = tick_t'(GAMMA_LEN);
    localparam tick_t HALF_T = tick_t'(half_len(GAMMA_LEN));
    unpack_state_t state_q, state_d, eff_state;
    tick_t         tick_q, tick_d, eff_tick, waddr, raddr;
    logic          wbank_q, eff_bank;
    logic          in_range, act, play, we0, we1;
    logic [P-1:0]  rd0, rd1, dout0_q, dout1_q;
    logic          valid_q, ovr_q;
    // A grst cycle already behaves as tick 0 of the new gamma, in the new state and bank.
    always_comb begin
        eff_tick  = grst ? '0 : tick_q;
        eff_bank  = grst ? ~wbank_q : wbank_q;
        eff_state = grst ? ((state_q == IDLE) ? FILL : RUN) : state_q;
        in_range  = eff_tick < GL_T;
        act       = eff_state != IDLE;
        play      = (eff_state == RUN) && in_range;
        we0       = act && in_valid && in_range && (eff_tick < HALF_T);
        we1       = act && in_valid && in_range && (eff_tick >= HALF_T);
        waddr     = (eff_tick < HALF_T) ? tick_t'(eff_tick << 1) : tick_t'((eff_tick - HALF_T) << 1);
        raddr     = in_range ? eff_tick : '0;
        tick_d    = in_range ? eff_tick + tick_t'(1) : GL_T;
        state_d   = eff_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            wbank_q <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            wbank_q <= eff_bank;
            dout0_q <= play ? rd0 : '0;
            dout1_q <= play ? rd1 : '0;
            valid_q <= play;
            ovr_q   <= ovr_q | (act && !in_range);
        end
    end
    spike_unpack_bank #(.P(P), .GAMMA_LEN(GAMMA_LEN)) u_ctx0 (
        .clk(clk), .rst(rst), .clr_i(grst), .clr_bank_i(eff_bank),
        .we_i(we0), .wbank_i(eff_bank), .waddr_i(waddr), .wdata_i(data_in),
        .rbank_i(~eff_bank), .raddr_i(raddr), .rdata_o(rd0)
    );
    spike_unpack_bank #(.P(P), .GAMMA_LEN(GAMMA_LEN)) u_ctx1 (
        .clk(clk), .rst(rst), .clr_i(grst), .clr_bank_i(eff_bank),
        .we_i(we1), .wbank_i(eff_bank), .waddr_i(waddr), .wdata_i(data_in),
        .rbank_i(~eff_bank), .raddr_i(raddr), .rdata_o(rd1)
    );
    assign data_out0 = dout0_q;
    assign data_out1 = dout1_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
endmodule

// File: doc/spike_unpack_buffer.md
# spike_unpack_buffer

Decompression stage for the multiplexed macro column. It takes the time-compressed spike stream the shared column emits and splits it back into two per-context spike streams at the original tick rate. Within each gamma cycle the column emits context 0 in the first half and context 1 in the second half. Each compressed tick expands to two original ticks. The block double-buffers one gamma cycle and plays it out during the next gamma cycle, feeding the two downstream column contexts.

## Interface
- P, 64, spike lines per context
- GAMMA_LEN, 10, original ticks per gamma cycle; must be even and ≥2; HALF = GAMMA_LEN/2
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- grst  in  1  gamma boundary strobe, one cycle high, sampled on clk; the grst cycle is tick 0 of a new gamma
- data_in  in  P  compressed spike stream from the column
- in_valid  in  1  data_in qualifier; when low, the tick writes nothing (slot stays 0)
- data_out0  out  P  context-0 spikes, original rate, registered
- data_out1  out  P  context-1 spikes, original rate, registered
- out_valid  out  1  data_out0/1 carry a playout tick
- overrun  out  1  sticky: a tick arrived after GAMMA_LEN ticks without grst

## Operation
- Storage: two banks (A/B); each bank holds ctx0[GAMMA_LEN][P] and ctx1[GAMMA_LEN][P].
- Registers: wbank (write bank), tick_cnt (0..GAMMA_LEN, saturating), state, output registers, overrun.
- Effective values per cycle: eff_tick = grst ? 0 : tick_cnt; eff_bank = grst ? ~wbank : wbank.
- On grst, the whole eff_bank is cleared to 0 in that cycle; the tick-0 write then lands on top of the cleared bank.
- Write mapping, when in_valid and eff_tick < GAMMA_LEN:
  - k = eff_tick < HALF: ctx0[2k] ← data_in
  - k ≥ HALF: ctx1[2(k−HALF)] ← data_in
  - Odd positions stay 0 (see Configuration).
- Read: position eff_tick of bank ~eff_bank goes into data_out0/1 when state = RUN and eff_tick < GAMMA_LEN; otherwise outputs load 0 and out_valid loads 0.
- State machine:
  - IDLE → FILL on the first grst.
  - FILL → RUN on the next grst.
  - RUN holds until rst.
  - In IDLE, nothing is written and outputs are 0.
- tick_cnt updates to min(eff_tick+1, GAMMA_LEN); wbank updates to eff_bank.
- Long gamma: when eff_tick = GAMMA_LEN without grst, the data is dropped, no write occurs, overrun is set (sticky until rst), outputs are 0 and out_valid is 0.
- Short gamma (grst before GAMMA_LEN ticks): the unwritten positions keep their cleared value of 0; this is not an error.
- grst together with in_valid: the write goes to the new bank at position 0 (ctx0[0]).

## Timing
- Reset (asynchronous): data_out0 = 0, data_out1 = 0, out_valid = 0, overrun = 0, state = IDLE, tick_cnt = 0, wbank = A, both banks 0.
- Output latency: original tick t of gamma g appears on data_out at cycle grst(g+1) + t + 1. End to end this is one gamma cycle plus one clock.
- out_valid is high for exactly min(GAMMA_LEN, gamma length) consecutive cycles per RUN gamma.
- rst asserted mid-gamma: all state is lost; the first post-reset grst re-enters FILL.

## Configuration
- SPIKE_UNPACK_DUP_EN defined: each compressed write also writes position 2k+1 with the same data, so a spike is held for two original ticks.
- Undefined: only position 2k is written; 2k+1 stays 0.

## Structure
- Package spike_unpack_pkg holds:
  - typedef enum {IDLE, FILL, RUN} unpack_state_t
  - function half_len(GAMMA_LEN)
  - a tick index typedef sized $clog2(GAMMA_LEN+1)
- Sub-module spike_unpack_bank: one context × ping-pong storage with clear, write port and read port; instantiated twice (ctx0, ctx1).

## Test plan
All scenarios use P=4, GAMMA_LEN=10.
- Reset then idle: no grst for 20 cycles → all outputs 0, state stays IDLE.
- Basic mapping: grst period 10; gamma 1 data_in = 1,2,3,4,5 then 6,7,8,9,A. During gamma 2, data_out0 = 1,0,2,0,3,0,4,0,5,0 and data_out1 = 6,0,7,0,8,0,9,0,A,0, starting grst+1. out_valid is high 10 cycles.
- Ping-pong: three consecutive gammas with distinct data → each playout matches the previous gamma only; a zero-input gamma yields all-zero playout with no stale data.
- Short gamma: grst after 6 ticks (ctx1 gets only tick 5 = F) → next playout data_out1 = F at t=0 and 0 elsewhere; out_valid high 10 cycles if the next gamma is 10 long.
- Long gamma: 12 ticks without grst → overrun = 1 at tick 11 and stays set after later grsts; ticks 10–11 are dropped.
- SPIKE_UNPACK_DUP_EN build: repeat the basic mapping test → data_out0 = 1,1,2,2,3,3,4,4,5,5.
